// File: rtl/pipe_flush_ctrl_if.sv
// Signal bundle between the WB/IF/preIF pipeline side and the flush/redirect controller.
// The controller uses the master modport; the pipeline (or a bench) uses slave.
interface pipe_flush_ctrl_if;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic        ertn_flush;
    logic        tlb_flush;
    logic [31:0] wb_pc;
    logic [31:0] csr_eentry;
    logic [31:0] csr_tlbrentry;
    logic [31:0] csr_era;
    logic [1:0]  if_inflight_cnt;
    logic        if_rdata_ok;
    logic        preif_allowin;
    logic        flush_out;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_discard;
    logic        busy;

    modport master (
        input  wb_ex, wb_ecode, ertn_flush, tlb_flush, wb_pc,
        input  csr_eentry, csr_tlbrentry, csr_era,
        input  if_inflight_cnt, if_rdata_ok, preif_allowin,
        output flush_out, redirect_valid, redirect_pc, if_discard, busy
    );

    modport slave (
        output wb_ex, wb_ecode, ertn_flush, tlb_flush, wb_pc,
        output csr_eentry, csr_tlbrentry, csr_era,
        output if_inflight_cnt, if_rdata_ok, preif_allowin,
        input  flush_out, redirect_valid, redirect_pc, if_discard, busy
    );
endinterface

// File: rtl/pipe_flush_ctrl.sv
// Central flush/redirect controller: turns committed WB events into a same-cycle flush,
// a held redirect toward preIF, and a counter that drops stale in-flight fetch responses.
module pipe_flush_ctrl #(
    parameter int         MAX_OUTSTANDING = 3,
    parameter logic [5:0] ECODE_TLBR      = 6'h3F
) (
    input  logic              clk,
    input  logic              reset,
    pipe_flush_ctrl_if.master bus
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {
        IDLE,
        PENDING
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               event_any;
    logic [31:0]        target;
    logic [31:0]        redirect_pc_q;
    logic [CNT_W-1:0]   discard_cnt;

    // Responses still owed by the bus after a flush; the beat returning in the
    // flush cycle itself is already killed by flush_out, so it is not counted.
    function automatic logic [CNT_W-1:0] sat_capture(input logic [1:0] inflight,
                                                      input logic       beat);
        int v;
        v = int'(inflight) - int'(beat);
        if (v < 0)
            v = 0;
        if (v > MAX_OUTSTANDING)
            v = MAX_OUTSTANDING;
        return CNT_W'(v);
    endfunction

    assign event_any = bus.wb_ex | bus.ertn_flush | bus.tlb_flush;

    always_comb begin
        target = bus.wb_pc + 32'd4;
        if (bus.wb_ex)
            target = (bus.wb_ecode == ECODE_TLBR) ? bus.csr_tlbrentry : bus.csr_eentry;
        else if (bus.ertn_flush)
            target = bus.csr_era;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // A new event always wins over a simultaneous allowin: the old redirect is abandoned.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (event_any)
                    state_nxt = PENDING;
            end
            PENDING: begin
                if (event_any)
                    state_nxt = PENDING;
                else if (bus.preif_allowin)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            redirect_pc_q <= 32'd0;
        else if (event_any)
            redirect_pc_q <= target;
    end

    always_ff @(posedge clk) begin
        if (reset)
            discard_cnt <= '0;
        else if (event_any)
            discard_cnt <= sat_capture(bus.if_inflight_cnt, bus.if_rdata_ok);
        else if ((discard_cnt != '0) && bus.if_rdata_ok)
            discard_cnt <= discard_cnt - CNT_W'(1);
    end

    assign bus.flush_out      = event_any & ~reset;
    assign bus.redirect_valid = (state == PENDING);
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.if_discard     = (discard_cnt != '0) & bus.if_rdata_ok;
    assign bus.busy           = (state == PENDING) | (discard_cnt != '0);
endmodule

// File: doc/pipe_flush_ctrl.md
Name: pipe_flush_ctrl

Overview:
- Central flush/redirect controller for the 5-stage LoongArch pipeline.
- Consumes committed WB-stage events: exception, ertn, TLB-refetch flush.
- Produces:
  - a same-cycle flush to all stages;
  - a held redirect PC toward preIF, using a valid/allowin handshake;
  - a counter that discards stale instruction-fetch responses still in flight on the bus at flush time.

Parameters:
- MAX_OUTSTANDING, 3, maximum fetch requests outstanding on the instruction bus; sets discard counter width to clog2(MAX_OUTSTANDING+1).
- ECODE_TLBR, 6'h3F, ecode that selects the TLB-refill entry.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- wb_ex  input  1  WB exception commit (already qualified by WB valid)
- wb_ecode  input  6  exception primary code
- ertn_flush  input  1  WB ertn commit
- tlb_flush  input  1  WB refetch flush (tlbwr/tlbfill/tlbrd/csr TLB update)
- wb_pc  input  32  PC of the WB instruction
- csr_eentry  input  32  EENTRY CSR value
- csr_tlbrentry  input  32  TLBRENTRY CSR value
- csr_era  input  32  ERA CSR value
- if_inflight_cnt  input  2  fetch requests issued but not yet returned (current cycle)
- if_rdata_ok  input  1  fetch response beat returning this cycle
- preif_allowin  input  1  preIF accepts a redirect this cycle
- flush_out  output  1  flush every stage, IF..WB
- redirect_valid  output  1  redirect PC valid toward preIF
- redirect_pc  output  32  redirect target
- if_discard  output  1  drop the fetch response returning this cycle
- busy  output  1  redirect pending or discards outstanding

Behaviour:
Reset:
- state IDLE; redirect_valid=0; redirect_pc=0; discard_cnt=0.
- if_discard=0; busy=0; flush_out=0 (event inputs ignored while reset=1).

Event and target:
- event = wb_ex | ertn_flush | tlb_flush.
- Priority: wb_ex > ertn_flush > tlb_flush.
- Target selection:
  - wb_ex with wb_ecode==ECODE_TLBR -> csr_tlbrentry;
  - other wb_ex -> csr_eentry;
  - ertn -> csr_era;
  - tlb_flush -> wb_pc+4 (32-bit wrap, 32'hFFFFFFFC+4 = 0).
- flush_out = event & ~reset; combinational, same cycle, 1 cycle per event.

FSM (2 states):
- IDLE:
  - redirect_valid=0.
  - On event: latch redirect_pc=target; go PENDING next cycle.
- PENDING:
  - redirect_valid=1; redirect_pc held stable.
  - If preif_allowin=1 and no new event: handshake completes this cycle; go IDLE.
  - If a new event arrives in PENDING: re-latch the new target, stay PENDING. A new event overrides a simultaneous preif_allowin, so no handshake completes that cycle.
- Redirect latency: event at cycle N -> redirect_valid=1 from N+1. Earliest handshake is at N+1.

Discard counter:
- On event: discard_cnt <= if_inflight_cnt - (if_rdata_ok ? 1 : 0), saturating at 0. The beat returning in the flush cycle is already killed by flush_out.
- Otherwise, while discard_cnt!=0 and if_rdata_ok: decrement by 1.
- if_discard = (discard_cnt != 0) & if_rdata_ok, combinational.
- Counter never exceeds MAX_OUTSTANDING, never underflows.
- Redirect handshake is independent of the counter: preIF may reissue while discards remain.
- New event while discard_cnt!=0: overwrite with the new capture.

Other:
- busy = (state==PENDING) | (discard_cnt != 0).
- Reset mid-operation returns to the reset state next edge; no redirect or discard survives reset.

Test Plan:
1. Syscall ex: wb_ex=1, ecode=0x0B, csr_eentry=0x1C008000, inflight=0.
   - Required: flush_out=1 in cycle N; redirect_valid=1, pc=0x1C008000 at N+1.
   - Release: preif_allowin=1 at N+2 -> IDLE at N+3, busy=0.
2. TLBR ex and ertn:
   - wb_ex with ecode=0x3F, tlbrentry=0x1C00F000 -> redirect_pc=0x1C00F000.
   - Separately, ertn with csr_era=0x1C000104 -> redirect_pc=0x1C000104.
   - Simultaneous wb_ex+ertn -> exception target wins.
3. tlb_flush with wb_pc=0x1C000200 -> redirect_pc=0x1C000204.
   - Hold preif_allowin=0 for 5 cycles -> redirect_valid and pc stay stable throughout; release on allowin.
4. Event with if_inflight_cnt=2, if_rdata_ok=0:
   - Next two if_rdata_ok beats -> if_discard=1 on each; third beat -> if_discard=0; busy falls after second beat.
   - Same event with if_rdata_ok=1 in the flush cycle -> only one later beat discarded.
5. New event in PENDING: eentry target pending, then ertn (era=0x1C000300) arrives while preif_allowin=1.
   - Required: no handshake that cycle; redirect_pc=0x1C000300 next cycle; flush_out pulses again.
6. Assert reset during PENDING with discard_cnt=2 -> next cycle redirect_valid=0, busy=0, redirect_pc=0, and the next if_rdata_ok gives if_discard=0.
